// File: rtl/motion_object_scanner.sv
// motion_object_scanner: per-scanline walker over motion-object RAM.
// Fetches picture/vpos for each object and strobes the vertical-control
// stage. Objects that match are handed to the line-buffer stage over a
// valid/ready handshake.
module motion_object_scanner #(
   parameter int NUM_OBJ      = 32,
   parameter int MAX_PER_LINE = 8
) (
   input  logic                          clk,
   input  logic                          RESETn,
   input  logic                          ce,
   input  logic                          LINE_START,
   output logic [$clog2(NUM_OBJ)+1:0]    OBJ_ADDR,
   input  logic [7:0]                    OBJ_DATA,
   output logic [15:0]                   SR,
   output logic                          CK1,
   input  logic                          MATCHn,
   output logic                          MO_VALID,
   input  logic                          MO_READY,
   output logic [7:0]                    MO_PIC,
   output logic [7:0]                    MO_ATTR,
   output logic [7:0]                    MO_HPOS,
   output logic                          SCAN_DONE,
   output logic                          OVERFLOW,
   output logic [3:0]                    MATCH_COUNT
);

   localparam int                 IDX_W    = $clog2(NUM_OBJ);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);
   localparam logic [3:0]         MAX_CNT  = 4'(MAX_PER_LINE);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_PIC, S_RD_VPOS, S_EVAL, S_TEST,
      S_RD_ATTR, S_RD_HPOS, S_EMIT, S_NEXT, S_DONE
   } state_t;

   state_t            r_state, w_next;
   logic [IDX_W-1:0]  r_idx;
   logic [15:0]       r_sr;
   logic              r_mo_valid;
   logic [7:0]        r_mo_pic, r_mo_attr, r_mo_hpos;
   logic              r_scan_done, r_overflow;
   logic [3:0]        r_match_cnt;
   logic [1:0]        w_byte;
   logic [3:0]        w_cnt_inc;
   logic              w_accept;
   logic              w_last_obj;

   assign w_cnt_inc  = r_match_cnt + 4'd1;
   assign w_accept   = r_mo_valid & MO_READY;
   assign w_last_obj = (r_idx == LAST_IDX);

   // State register; advances only on pixel-clock-enable ticks
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn)  r_state <= S_IDLE;
      else if (ce)  r_state <= w_next;
   end

   // Next state, RAM byte select and CK1 strobe; LINE_START overrides everything
   always_comb begin
      w_next = r_state;
      w_byte = 2'd0;
      CK1    = 1'b0;
      case (r_state)
         S_RD_VPOS: w_byte = 2'd1;
         S_EVAL:    CK1    = 1'b1;
         S_RD_ATTR: w_byte = 2'd2;
         S_RD_HPOS: w_byte = 2'd3;
         default:   ;
      endcase
      if (LINE_START) begin
         w_next = S_RD_PIC;
      end else begin
         case (r_state)
            S_RD_PIC:  w_next = S_RD_VPOS;
            S_RD_VPOS: w_next = S_EVAL;
            S_EVAL:    w_next = S_TEST;
            S_TEST:    w_next = MATCHn ? S_NEXT : S_RD_ATTR;
            S_RD_ATTR: w_next = S_RD_HPOS;
            S_RD_HPOS: w_next = S_EMIT;
            S_EMIT:    if (w_accept) w_next = (w_cnt_inc == MAX_CNT) ? S_DONE : S_NEXT;
            S_NEXT:    w_next = w_last_obj ? S_DONE : S_RD_PIC;
            default:   w_next = r_state;   // IDLE and DONE wait for LINE_START
         endcase
      end
   end

   // Datapath: object fetch latches, descriptor handoff, per-line counters
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         r_idx       <= '0;
         r_sr        <= '0;
         r_mo_valid  <= 1'b0;
         r_mo_pic    <= '0;
         r_mo_attr   <= '0;
         r_mo_hpos   <= '0;
         r_scan_done <= 1'b1;
         r_overflow  <= 1'b0;
         r_match_cnt <= '0;
      end else if (ce) begin
         if (LINE_START) begin
            // Restart drops any descriptor still waiting for MO_READY
            r_idx       <= '0;
            r_mo_valid  <= 1'b0;
            r_scan_done <= 1'b0;
            r_overflow  <= 1'b0;
            r_match_cnt <= '0;
         end else begin
            case (r_state)
               S_RD_PIC:  r_sr[7:0]  <= OBJ_DATA;
               S_RD_VPOS: r_sr[15:8] <= OBJ_DATA;
               S_RD_ATTR: begin
                  r_mo_attr <= OBJ_DATA;
                  r_mo_pic  <= r_sr[7:0];
               end
               S_RD_HPOS: begin
                  r_mo_hpos  <= OBJ_DATA;
                  r_mo_valid <= 1'b1;
               end
               S_EMIT: if (w_accept) begin
                  r_mo_valid  <= 1'b0;
                  r_match_cnt <= w_cnt_inc;
                  if (w_cnt_inc == MAX_CNT) begin
                     r_scan_done <= 1'b1;
                     // Filling up on the very last object is not an overflow
                     r_overflow  <= !w_last_obj;
                  end
               end
               S_NEXT: begin
                  if (w_last_obj) r_scan_done <= 1'b1;
                  else            r_idx       <= r_idx + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign OBJ_ADDR    = {r_idx, w_byte};
   assign SR          = r_sr;
   assign MO_VALID    = r_mo_valid;
   assign MO_PIC      = r_mo_pic;
   assign MO_ATTR     = r_mo_attr;
   assign MO_HPOS     = r_mo_hpos;
   assign SCAN_DONE   = r_scan_done;
   assign OVERFLOW    = r_overflow;
   assign MATCH_COUNT = r_match_cnt;

endmodule

// File: tb/tb_motion_object_scanner.sv
// Testbench for motion_object_scanner: object RAM model, vertical-control
// model keyed on vpos 0xF0, and a descriptor scoreboard.
module tb_motion_object_scanner;

   logic        clk = 1'b0;
   logic        RESETn, ce, LINE_START, MATCHn, MO_READY;
   logic [6:0]  OBJ_ADDR;
   logic [7:0]  OBJ_DATA;
   logic [15:0] SR;
   logic        CK1, MO_VALID, SCAN_DONE, OVERFLOW;
   logic [7:0]  MO_PIC, MO_ATTR, MO_HPOS;
   logic [3:0]  MATCH_COUNT;

   logic [7:0]  mem [128];
   logic [23:0] exp_q[$];
   logic [23:0] obs_q[$];
   int          checks = 0;
   int          errors = 0;

   localparam logic [54:0] RESET_VEC = {16'h0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 4'h0, 7'h0};

   motion_object_scanner dut (
      .clk(clk), .RESETn(RESETn), .ce(ce), .LINE_START(LINE_START),
      .OBJ_ADDR(OBJ_ADDR), .OBJ_DATA(OBJ_DATA), .SR(SR), .CK1(CK1), .MATCHn(MATCHn),
      .MO_VALID(MO_VALID), .MO_READY(MO_READY), .MO_PIC(MO_PIC), .MO_ATTR(MO_ATTR),
      .MO_HPOS(MO_HPOS), .SCAN_DONE(SCAN_DONE), .OVERFLOW(OVERFLOW), .MATCH_COUNT(MATCH_COUNT)
   );

   always #5 clk = ~clk;

   assign OBJ_DATA = mem[OBJ_ADDR];

   // Vertical control: an object is on this line when its vpos is 0xF0
   always @(posedge clk or negedge RESETn) begin
      if (!RESETn)         MATCHn <= 1'b1;
      else if (ce && CK1)  MATCHn <= (SR[15:8] != 8'hF0);
   end

   function automatic logic [54:0] out_vec();
      return {SR, CK1, MO_VALID, MO_PIC, MO_ATTR, MO_HPOS, SCAN_DONE, OVERFLOW, MATCH_COUNT, OBJ_ADDR};
   endfunction

   // Advance one clock; records any descriptor handed off at this edge
   task automatic tick();
      if (ce && MO_VALID && MO_READY) obs_q.push_back({MO_PIC, MO_ATTR, MO_HPOS});
      @(posedge clk);
      #1;
   endtask

   task automatic load_mem(input logic [31:0] mask);
      for (int i = 0; i < 32; i++) begin
         mem[i*4+0] = 8'h80 + 8'(i);
         mem[i*4+1] = mask[i] ? 8'hF0 : 8'h00;
         mem[i*4+2] = 8'h20 + 8'(i);
         mem[i*4+3] = 8'(i * 3);
      end
   endtask

   task automatic push_exp(input logic [31:0] mask, input int limit);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++)
         if (mask[i] && n < limit) begin
            exp_q.push_back({mem[i*4+0], mem[i*4+2], mem[i*4+3]});
            n++;
         end
   endtask

   task automatic line_start();
      LINE_START = 1'b1;
      tick();
      LINE_START = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!SCAN_DONE && n < 1000) begin tick(); n++; end
   endtask

   task automatic test_reset();
      RESETn = 1'b1; ce = 1'b0; LINE_START = 1'b0; MO_READY = 1'b0;
      load_mem(32'h0);
      #3 RESETn = 1'b0;
      #4;
      checks++; if (out_vec() !== RESET_VEC) begin errors++; $display("FAIL reset_state got %h want %h", out_vec(), RESET_VEC); end
      @(negedge clk) RESETn = 1'b1;
      ce = 1'b1;
      tick();
   endtask

   task automatic test_no_match();
      int n, ck, v;
      load_mem(32'h0); MO_READY = 1'b1;
      line_start();
      n = 0; ck = 0; v = 0;
      while (!SCAN_DONE && n < 400) begin
         if (CK1) ck++;
         if (MO_VALID) v++;
         tick(); n++;
      end
      checks++; if (n !== 160) begin errors++; $display("FAIL nomatch_ticks got %0d want 160", n); end
      checks++; if (ck !== 32) begin errors++; $display("FAIL nomatch_ck1 got %0d want 32", ck); end
      checks++; if (v !== 0) begin errors++; $display("FAIL nomatch_valid got %0d want 0", v); end
      checks++; if ({OVERFLOW, MATCH_COUNT} !== 5'h0) begin errors++; $display("FAIL nomatch_cnt got %h want 0", {OVERFLOW, MATCH_COUNT}); end
   endtask

   task automatic test_single_match();
      int n, v;
      logic [23:0] e, o;
      load_mem(32'h20);
      mem[20] = 8'h12; mem[22] = 8'h03; mem[23] = 8'h40;
      exp_q.push_back(24'h120340);
      MO_READY = 1'b1;
      line_start();
      n = 0; v = 0;
      while (!SCAN_DONE && n < 400) begin
         if (MO_VALID) v++;
         tick(); n++;
      end
      checks++; if (SCAN_DONE !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", SCAN_DONE); end
      checks++; if (v !== 1) begin errors++; $display("FAIL single_valid_ticks got %0d want 1", v); end
      checks++; if ({OVERFLOW, MATCH_COUNT} !== 5'h1) begin errors++; $display("FAIL single_cnt got %h want 01", {OVERFLOW, MATCH_COUNT}); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL single_desc got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_backpressure();
      int n, stable;
      logic [23:0] snap, e, o;
      load_mem(32'h20);
      mem[20] = 8'h12; mem[22] = 8'h03; mem[23] = 8'h40;
      exp_q.push_back(24'h120340);
      MO_READY = 1'b0;
      line_start();
      n = 0;
      while (!MO_VALID && n < 400) begin tick(); n++; end
      snap = {MO_PIC, MO_ATTR, MO_HPOS};
      checks++; if (snap !== 24'h120340 || MO_VALID !== 1'b1) begin errors++; $display("FAIL bp_first got %b/%h want 1/120340", MO_VALID, snap); end
      stable = 0;
      repeat (10) begin
         tick();
         if (MO_VALID && {MO_PIC, MO_ATTR, MO_HPOS} == snap) stable++;
      end
      checks++; if (stable !== 10) begin errors++; $display("FAIL bp_stable got %0d want 10", stable); end
      MO_READY = 1'b1;
      tick();
      checks++; if ({MO_VALID, MATCH_COUNT} !== 5'h01) begin errors++; $display("FAIL bp_accept got %h want 01", {MO_VALID, MATCH_COUNT}); end
      tick();
      checks++; if (OBJ_ADDR !== 7'h18) begin errors++; $display("FAIL bp_next_addr got %h want 18", OBJ_ADDR); end
      wait_done(n);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL bp_desc got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overflow();
      int n, ck, ck2;
      logic [23:0] e, o;
      load_mem(32'h0000_1FF8);
      push_exp(32'h0000_1FF8, 8);
      MO_READY = 1'b1;
      line_start();
      n = 0; ck = 0;
      while (!SCAN_DONE && n < 400) begin
         if (CK1) ck++;
         tick(); n++;
      end
      checks++; if ({SCAN_DONE, OVERFLOW, MATCH_COUNT} !== 6'b11_1000) begin errors++; $display("FAIL ovf_flags got %b want 111000", {SCAN_DONE, OVERFLOW, MATCH_COUNT}); end
      checks++; if (ck !== 11) begin errors++; $display("FAIL ovf_ck1 got %0d want 11", ck); end
      ck2 = 0;
      repeat (20) begin if (CK1) ck2++; tick(); end
      checks++; if (ck2 !== 0) begin errors++; $display("FAIL ovf_ck1_after got %0d want 0", ck2); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL ovf_desc got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_full_at_last();
      int n;
      logic [23:0] e, o;
      load_mem(32'hFF00_0000);
      push_exp(32'hFF00_0000, 8);
      MO_READY = 1'b1;
      line_start();
      wait_done(n);
      checks++; if ({SCAN_DONE, OVERFLOW, MATCH_COUNT} !== 6'b10_1000) begin errors++; $display("FAIL last_flags got %b want 101000", {SCAN_DONE, OVERFLOW, MATCH_COUNT}); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL last_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL last_desc got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_restart();
      int n;
      logic [23:0] e, o;
      load_mem(32'h8);
      MO_READY = 1'b0;
      line_start();
      n = 0;
      while (!MO_VALID && n < 400) begin tick(); n++; end
      checks++; if ({MO_VALID, OBJ_ADDR} !== 8'h8C) begin errors++; $display("FAIL rs_emit got %h want 8c", {MO_VALID, OBJ_ADDR}); end
      line_start();
      checks++; if ({MO_VALID, SCAN_DONE, MATCH_COUNT, OBJ_ADDR} !== 13'h0) begin errors++; $display("FAIL rs_restart got %h want 0", {MO_VALID, SCAN_DONE, MATCH_COUNT, OBJ_ADDR}); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rs_dropped got %0d want 0", obs_q.size()); end
      push_exp(32'h8, 8);
      MO_READY = 1'b1;
      wait_done(n);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rs_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL rs_desc got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_ce_hold();
      int n, diff;
      logic [54:0] snap;
      load_mem(32'h0);
      MO_READY = 1'b1;
      line_start();
      repeat (7) tick();
      snap = out_vec();
      checks++; if (CK1 !== 1'b1) begin errors++; $display("FAIL ce_eval_ck1 got %b want 1", CK1); end
      ce = 1'b0; diff = 0;
      repeat (6) begin tick(); if (out_vec() !== snap) diff++; end
      checks++; if (diff !== 0) begin errors++; $display("FAIL ce_hold got %0d changes want 0", diff); end
      ce = 1'b1;
      wait_done(n);
      checks++; if (n + 7 !== 160) begin errors++; $display("FAIL ce_total_ticks got %0d want 160", n + 7); end
   endtask

   task automatic test_reset_mid();
      load_mem(32'h0);
      line_start();
      tick();
      checks++; if ({SR[7:0], OBJ_ADDR} !== {8'h80, 7'h01}) begin errors++; $display("FAIL rm_pre got %h want 8001", {SR[7:0], OBJ_ADDR}); end
      #2 RESETn = 1'b0;
      #1;
      checks++; if (out_vec() !== RESET_VEC) begin errors++; $display("FAIL rm_async got %h want %h", out_vec(), RESET_VEC); end
      @(negedge clk) RESETn = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_no_match();
      test_single_match();
      test_backpressure();
      test_overflow();
      test_full_at_last();
      test_restart();
      test_ce_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
